// File: rtl/fsm_cmd_pkg.sv
// rtl/fsm_cmd_pkg.sv - shared command types, gate states and legality decode
package fsm_cmd_pkg;

  // Raw 3-bit command code as seen by the downstream control FSM
  typedef logic [2:0] cmd_t;

  // Gate states: RUN forwards commands, LOCKED is sticky until reset
  typedef enum logic {
    RUN    = 1'b0,
    LOCKED = 1'b1
  } gate_state_t;

  // Highest code the downstream FSM understands
  localparam cmd_t CMD_LEGAL_MAX = 3'h5;

  // Code driven whenever nothing meaningful can be issued
  localparam cmd_t CMD_SAFE = 3'h0;

  // Legality decode with every encoding listed so none can slip through
  function automatic logic is_legal(input cmd_t code);
    logic ok;
    case (code)
      3'h0, 3'h1, 3'h2, 3'h3, 3'h4, 3'h5: ok = 1'b1;
      3'h6, 3'h7:                         ok = 1'b0;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - command FIFO with wrap-around pointers and synchronous flush
module cmd_fifo
  import fsm_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  cmd_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           push_ok;
  logic           pop_ok;

  // Guard the requests so a full push or empty pop cannot corrupt pointers
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage array is write-only on push; contents need no reset because count gates reads
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; flush empties in one edge
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        2'b11:   count <= count;
        2'b00:   count <= count;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fsm_cmd_gate.sv
// rtl/fsm_cmd_gate.sv - validates user commands, queues legal ones, locks out on repeated illegals
module fsm_cmd_gate
  import fsm_cmd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int LOCK_THRESH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  cmd_t       in_data,
  output logic       in_ready,
  output cmd_t       cmd_out,
  output logic       cmd_valid,
  output logic       reject_pulse,
  output logic [3:0] err_count,
  output logic       locked
);

  localparam logic [3:0] THRESH = 4'(LOCK_THRESH);

  gate_state_t state;
  logic [3:0]  consec;
  logic [3:0]  consec_inc;
  logic        accept;
  logic        push;
  logic        bad;
  logic        lock_hit;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  cmd_t        fifo_head;
  cmd_t        head_safe;

  // Handshake depends only on registered state so in_ready never loops back to in_valid
  assign in_ready = !fifo_full && (state == RUN);
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_legal(in_data);
  assign bad      = accept && !is_legal(in_data);

  assign consec_inc = (consec == 4'hF) ? consec : consec + 4'd1;
  assign lock_hit   = bad && (consec_inc >= THRESH);

  // The lockout edge flushes instead of issuing, so no pop is allowed on it
  assign pop = (state == RUN) && !fifo_empty && !lock_hit;

  // Queue contents are legal by construction; this only keeps cmd_out in range defensively
  assign head_safe = (fifo_head <= CMD_LEGAL_MAX) ? fifo_head : CMD_SAFE;

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (lock_hit),
    .push     (push),
    .push_data(in_data),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Error accounting: every dropped illegal command pulses once and bumps the saturating total
  always_ff @(posedge clk) begin
    if (rst) begin
      reject_pulse <= 1'b0;
      err_count    <= 4'h0;
    end else begin
      reject_pulse <= bad;
      if (bad && (err_count != 4'hF)) begin
        err_count <= err_count + 4'd1;
      end
    end
  end

  // Gate FSM: issues one queued command per cycle in RUN, parks on a safe code once LOCKED
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      locked    <= 1'b0;
      consec    <= 4'h0;
      cmd_out   <= CMD_SAFE;
      cmd_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (lock_hit) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            consec    <= consec_inc;
            cmd_out   <= CMD_SAFE;
            cmd_valid <= 1'b0;
          end else begin
            if (push) begin
              consec <= 4'h0;
            end else if (bad) begin
              consec <= consec_inc;
            end
            if (pop) begin
              cmd_out   <= head_safe;
              cmd_valid <= 1'b1;
            end else begin
              cmd_valid <= 1'b0;
            end
          end
        end
        LOCKED: begin
          state     <= LOCKED;
          locked    <= 1'b1;
          cmd_out   <= CMD_SAFE;
          cmd_valid <= 1'b0;
        end
        default: begin
          state     <= LOCKED;
          locked    <= 1'b1;
          cmd_out   <= CMD_SAFE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_cmd_gate.sv
// tb/tb_fsm_cmd_gate.sv - directed bench with a queue-level reference model for two lock thresholds
module tb_fsm_cmd_gate;

  localparam int DEPTH = 4;
  localparam int NI    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = 3'h0;

  logic       ready_a, valid_a, rej_a, lock_a;
  logic [2:0] out_a;
  logic [3:0] err_a;
  logic       ready_b, valid_b, rej_b, lock_b;
  logic [2:0] out_b;
  logic [3:0] err_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fsm_cmd_gate #(.DEPTH(DEPTH), .LOCK_THRESH(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready_a), .cmd_out(out_a), .cmd_valid(valid_a),
    .reject_pulse(rej_a), .err_count(err_a), .locked(lock_a)
  );

  fsm_cmd_gate #(.DEPTH(DEPTH), .LOCK_THRESH(15)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready_b), .cmd_out(out_b), .cmd_valid(valid_b),
    .reject_pulse(rej_b), .err_count(err_b), .locked(lock_b)
  );

  // Reference model: a plain list of queued codes plus counters, one set per instance
  int         m_thresh [NI] = '{3, 15};
  logic [2:0] m_q      [NI][DEPTH];
  int         m_cnt    [NI];
  logic [2:0] m_out    [NI];
  bit         m_val    [NI];
  bit         m_rej    [NI];
  bit         m_lock   [NI];
  int         m_err    [NI];
  int         m_cons   [NI];

  task automatic model_step(input int k);
    bit         acc;
    bit         issue;
    bit         newlock;
    logic [2:0] head;
    if (rst) begin
      m_cnt[k] = 0; m_out[k] = 3'h0; m_val[k] = 0; m_rej[k] = 0;
      m_lock[k] = 0; m_err[k] = 0; m_cons[k] = 0;
      return;
    end
    acc     = in_valid && !m_lock[k] && (m_cnt[k] < DEPTH);
    issue   = !m_lock[k] && (m_cnt[k] > 0);
    head    = m_q[k][0];
    newlock = 0;
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) m_q[k][i] = m_q[k][i+1];
      m_cnt[k] = m_cnt[k] - 1;
    end
    m_rej[k] = 0;
    if (acc) begin
      if (in_data <= 3'h5) begin
        m_q[k][m_cnt[k]] = in_data;
        m_cnt[k] = m_cnt[k] + 1;
        m_cons[k] = 0;
      end else begin
        m_rej[k] = 1;
        m_err[k] = (m_err[k] < 15) ? m_err[k] + 1 : 15;
        m_cons[k] = m_cons[k] + 1;
        if (m_cons[k] >= m_thresh[k]) newlock = 1;
      end
    end
    if (newlock) begin
      m_lock[k] = 1; m_cnt[k] = 0; m_out[k] = 3'h0; m_val[k] = 0;
    end else if (issue) begin
      m_out[k] = head; m_val[k] = 1;
    end else begin
      m_val[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic rdy, input logic [2:0] co, input logic cv,
                          input logic rj, input logic [3:0] ec, input logic lk);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, ".in_ready"},     int'(rdy), int'(!m_lock[k] && (m_cnt[k] < DEPTH)));
    chk({p, ".cmd_out"},      int'(co),  int'(m_out[k]));
    chk({p, ".cmd_valid"},    int'(cv),  int'(m_val[k]));
    chk({p, ".reject_pulse"}, int'(rj),  int'(m_rej[k]));
    chk({p, ".err_count"},    int'(ec),  m_err[k]);
    chk({p, ".locked"},       int'(lk),  int'(m_lock[k]));
    chk({p, ".cmd_out_legal"}, int'(co <= 3'h5), 1);
  endtask

  // Every cycle, both instances are held against the model away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, ready_a, out_a, valid_a, rej_a, err_a, lock_a);
      cmp_inst(1, ready_b, out_b, valid_b, rej_b, err_b, lock_b);
    end
  end

  task automatic step(input bit v, input logic [2:0] d);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 3'h0);
    step(0, 3'h0);
    rst = 1'b0;
  endtask

  logic [2:0] stream [6] = '{3'h0, 3'h5, 3'h3, 3'h1, 3'h2, 3'h4};

  initial begin
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state
    do_reset();
    chk("rst.cmd_out", int'(out_a), 0);
    chk("rst.cmd_valid", int'(valid_a), 0);
    chk("rst.err_count", int'(err_a), 0);
    chk("rst.locked", int'(lock_a), 0);
    chk("rst.in_ready", int'(ready_a), 1);

    // Single legal command: two-cycle latency, then holds
    step(1, 3'h4);
    step(0, 3'h0);
    chk("lat.cmd_out", int'(out_a), 4);
    chk("lat.cmd_valid", int'(valid_a), 1);
    step(0, 3'h0);
    chk("hold.cmd_out", int'(out_a), 4);
    chk("hold.cmd_valid", int'(valid_a), 0);

    // Single illegal command
    do_reset();
    step(1, 3'h6);
    chk("ill.reject_pulse", int'(rej_a), 1);
    chk("ill.err_count", int'(err_a), 1);
    chk("ill.locked", int'(lock_a), 0);
    step(0, 3'h0);
    chk("ill.cmd_out", int'(out_a), 0);
    chk("ill.reject_clear", int'(rej_a), 0);

    // Lockout after three consecutive illegals, broken once by a legal code
    do_reset();
    step(1, 3'h7);
    step(1, 3'h1);
    step(1, 3'h6);
    chk("lk.issue1", int'(out_a), 1);
    step(1, 3'h6);
    chk("lk.not_yet", int'(lock_a), 0);
    step(1, 3'h7);
    chk("lk.locked", int'(lock_a), 1);
    chk("lk.err_count", int'(err_a), 4);
    chk("lk.reject", int'(rej_a), 1);
    chk("lk.cmd_out", int'(out_a), 0);
    chk("lk.in_ready", int'(ready_a), 0);
    chk("lk.b_locked", int'(lock_b), 0);
    step(1, 3'h2);
    step(1, 3'h2);
    chk("lk.in_ready_stays", int'(ready_a), 0);
    chk("lk.err_frozen", int'(err_a), 4);
    chk("lk.valid_stays", int'(valid_a), 0);

    // Back-to-back stream keeps pace with no loss
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(i < 6, (i < 6) ? stream[i] : 3'h0);
      chk("bb.in_ready", int'(ready_a), 1);
      if (i >= 1 && i <= 6) begin
        chk("bb.cmd_out", int'(out_a), int'(stream[i-1]));
        chk("bb.cmd_valid", int'(valid_a), 1);
      end
    end

    // Lock after traffic, then a one-cycle reset recovers normal issue
    do_reset();
    step(1, 3'h1); step(1, 3'h2); step(1, 3'h3); step(1, 3'h4);
    step(1, 3'h6); step(1, 3'h7); step(1, 3'h6);
    chk("rl.locked", int'(lock_a), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'h0);
      chk("rl.cmd_valid", int'(valid_a), 0);
      chk("rl.cmd_out", int'(out_a), 0);
    end
    rst = 1'b1;
    step(0, 3'h0);
    rst = 1'b0;
    chk("rl.rst_locked", int'(lock_a), 0);
    chk("rl.rst_err", int'(err_a), 0);
    chk("rl.rst_valid", int'(valid_a), 0);
    chk("rl.rst_reject", int'(rej_a), 0);
    chk("rl.in_ready", int'(ready_a), 1);
    step(1, 3'h5);
    step(0, 3'h0);
    chk("rl.issue5", int'(out_a), 5);
    chk("rl.valid5", int'(valid_a), 1);

    // Seventeen illegals, a legal after every two: count saturates, no lock
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1, (i % 2 == 1) ? 3'h7 : 3'h6);
      if (i % 2 == 1) step(1, 3'h3);
    end
    step(0, 3'h0);
    step(0, 3'h0);
    chk("sat.b_err", int'(err_b), 15);
    chk("sat.b_locked", int'(lock_b), 0);
    chk("sat.a_err", int'(err_a), 15);
    chk("sat.a_locked", int'(lock_a), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
